data_mem_ctrl: RTL and testbench

- Data-memory slave that sits directly downstream of the processor's Memory stage.
- Serves the processor data port (DataAddr/DataOut/ReadData/WriteData) and returns DataIn/DataWaitreq.
- Contains a word-addressed RAM, one memory-mapped I/O register and an unmapped-address detector.
- Inserts configurable wait states through DataWaitreq, so the pipeline stall path is exercised with realistic multi-cycle memory.

---
 rtl/data_mem_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Data-memory slave for the processor data port: word RAM, one I/O register,
// unmapped-address detection, and per-access wait states driven through DataWaitreq.
module data_mem_ctrl #(
    parameter int                   WORD_SIZE  = 16,
    parameter int                   DEPTH      = 256,
    parameter int                   RD_LATENCY = 2,
    parameter int                   WR_LATENCY = 1,
    parameter logic [WORD_SIZE-1:0] IO_ADDR    = 16'h1000
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [WORD_SIZE-1:0] DataAddr,
    input  logic [WORD_SIZE-1:0] DataOut,
    input  logic                 ReadData,
    input  logic                 WriteData,
    output logic [WORD_SIZE-1:0] DataIn,
    output logic                 DataWaitreq,
    input  logic [WORD_SIZE-1:0] IoIn,
    output logic [WORD_SIZE-1:0] IoOut,
    output logic                 ErrAddr
);

    if (RD_LATENCY < 1) begin : g_bad_rd_latency
        $error("data_mem_ctrl: RD_LATENCY must be >= 1");
    end
    if (WR_LATENCY < 1) begin : g_bad_wr_latency
        $error("data_mem_ctrl: WR_LATENCY must be >= 1");
    end

    localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int CW      = $clog2(MAX_LAT + 1);
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CW-1:0]        LAT_RD  = CW'(RD_LATENCY);
    localparam logic [CW-1:0]        LAT_WR  = CW'(WR_LATENCY);
    localparam logic [CW-1:0]        CNT_ONE = CW'(1);
    localparam logic [WORD_SIZE-1:0] DEPTH_W = WORD_SIZE'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [WORD_SIZE-1:0]   addr_q, addr_d;
    logic [WORD_SIZE-1:0]   wdata_q, wdata_d;
    logic                   wr_q, wr_d;
    logic [WORD_SIZE-1:0]   io_q, io_d;
    logic [WORD_SIZE-1:0]   rdata_q, rdata_d;
    logic [WORD_SIZE-1:0]   io_out_q, io_out_d;
    logic                   err_q, err_d;

    logic [WORD_SIZE-1:0]   mem [DEPTH];

    logic                   req;
    logic [CW-1:0]          lat_live;
    logic [WORD_SIZE-1:0]   sel_addr;
    logic [WORD_SIZE-1:0]   sel_io;
    logic [WORD_SIZE-1:0]   read_val;
    logic                   hit_ram;
    logic                   hit_io;
    logic                   ram_we;

    assign req      = ReadData | WriteData;
    assign lat_live = WriteData ? LAT_WR : LAT_RD;
    assign hit_ram  = (addr_q < DEPTH_W);
    assign hit_io   = (addr_q == IO_ADDR);
    assign ram_we   = (state_q == ST_ACK) && wr_q && hit_ram;

    // A latency-1 read samples straight off the live bus in IDLE; otherwise the captured copy.
    always_comb begin
        sel_addr = (state_q == ST_IDLE) ? DataAddr : addr_q;
        sel_io   = (state_q == ST_IDLE) ? IoIn : io_q;
        read_val = '0;
        if (sel_addr < DEPTH_W) begin
            read_val = mem[sel_addr[AW-1:0]];
        end else if (sel_addr == IO_ADDR) begin
            read_val = sel_io;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_d        = wr_q;
        io_d        = io_q;
        rdata_d     = rdata_q;
        io_out_d    = io_out_q;
        err_d       = err_q;
        DataWaitreq = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    DataWaitreq = 1'b1;
                    addr_d      = DataAddr;
                    wdata_d     = DataOut;
                    wr_d        = WriteData;
                    io_d        = IoIn;
                    rdata_d     = '0;
                    if (lat_live == CNT_ONE) begin
                        state_d = ST_ACK;
                        cnt_d   = '0;
                        if (!WriteData) begin
                            rdata_d = read_val;
                        end
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = lat_live - CNT_ONE;
                    end
                end
            end
            ST_BUSY: begin
                DataWaitreq = 1'b1;
                // cnt_q holds the wait cycles still owed, including this one.
                if (cnt_q <= CNT_ONE) begin
                    state_d = ST_ACK;
                    cnt_d   = '0;
                    if (!wr_q) begin
                        rdata_d = read_val;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                if (wr_q && hit_io) begin
                    io_out_d = wdata_q;
                end
                if (!hit_ram && !hit_io) begin
                    err_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            io_q     <= '0;
            rdata_q  <= '0;
            io_out_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wr_q     <= wr_d;
            io_q     <= io_d;
            rdata_q  <= rdata_d;
            io_out_q <= io_out_d;
            err_q    <= err_d;
        end
    end

    // RAM contents survive reset; commit is gated by the reset-cleared state register.
    always_ff @(posedge Clock) begin
        if (ram_we) begin
            mem[addr_q[AW-1:0]] <= wdata_q;
        end
    end

    assign DataIn  = ((state_q == ST_ACK) && !wr_q) ? rdata_q : '0;
    assign IoOut   = io_out_q;
    assign ErrAddr = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed scenarios plus randomized
// accesses checked against an array-based reference of the memory map.
module tb_data_mem_ctrl;

    localparam int          W     = 16;
    localparam int          DEPTH = 256;
    localparam int          RDL   = 2;
    localparam int          WRL   = 1;
    localparam logic [15:0] IOA   = 16'h1000;

    logic          Clock = 1'b0;
    logic          Reset;
    logic [W-1:0]  DataAddr;
    logic [W-1:0]  DataOut;
    logic          ReadData;
    logic          WriteData;
    logic [W-1:0]  DataIn;
    logic          DataWaitreq;
    logic [W-1:0]  IoIn;
    logic [W-1:0]  IoOut;
    logic          ErrAddr;

    always #5 Clock = ~Clock;

    data_mem_ctrl #(
        .WORD_SIZE (W),
        .DEPTH     (DEPTH),
        .RD_LATENCY(RDL),
        .WR_LATENCY(WRL),
        .IO_ADDR   (IOA)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .DataAddr   (DataAddr),
        .DataOut    (DataOut),
        .ReadData   (ReadData),
        .WriteData  (WriteData),
        .DataIn     (DataIn),
        .DataWaitreq(DataWaitreq),
        .IoIn       (IoIn),
        .IoOut      (IoOut),
        .ErrAddr    (ErrAddr)
    );

    int          errors = 0;
    int          checks = 0;
    logic [15:0] ref_mem [DEPTH];
    bit          ref_valid [DEPTH];
    logic [15:0] ref_io  = 16'h0;
    bit          ref_err = 1'b0;
    time         last_ack;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_read(input logic [15:0] a, input logic [15:0] io);
        if (int'(a) < DEPTH) return ref_mem[a[7:0]];
        if (a == IOA) return io;
        return 16'h0;
    endfunction

    // One complete access, entered and left at negedge+1 with the bus idle.
    task automatic access(input bit wr, input logic [15:0] a, input logic [15:0] d,
                          input bit use_alt, input logic [15:0] alt, input bit both,
                          input string tag);
        int          n;
        logic [15:0] exp_rd;
        exp_rd    = wr ? 16'h0 : ref_read(a, IoIn);
        DataAddr  = a;
        DataOut   = d;
        WriteData = wr;
        ReadData  = !wr || both;
        #1;
        n = 0;
        while (DataWaitreq === 1'b1 && n < 20) begin
            n++;
            @(negedge Clock);
            if (use_alt) begin
                DataAddr = alt;
                DataOut  = ~d;
                IoIn     = IoIn + 16'h0101;
            end
            #1;
        end
        check_val({tag, "_lat"}, 32'(n), wr ? WRL : RDL);
        check_val({tag, "_data"}, 32'(DataIn), 32'(exp_rd));
        last_ack = $time;
        @(negedge Clock);
        ReadData  = 1'b0;
        WriteData = 1'b0;
        if (int'(a) < DEPTH) begin
            if (wr) begin
                ref_mem[a[7:0]]   = d;
                ref_valid[a[7:0]] = 1'b1;
            end
        end else if (a == IOA) begin
            if (wr) ref_io = d;
        end else begin
            ref_err = 1'b1;
        end
        #1;
        check_val({tag, "_idle_wait"}, 32'(DataWaitreq), 32'h0);
        check_val({tag, "_idle_data"}, 32'(DataIn), 32'h0);
        check_val({tag, "_ioout"}, 32'(IoOut), 32'(ref_io));
        check_val({tag, "_err"}, 32'(ErrAddr), 32'(ref_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        time t0;
        Reset     = 1'b1;
        DataAddr  = '0;
        DataOut   = '0;
        ReadData  = 1'b0;
        WriteData = 1'b0;
        IoIn      = '0;
        repeat (2) @(negedge Clock);
        #1;
        check_val("rst_wait", 32'(DataWaitreq), 32'h0);
        check_val("rst_data", 32'(DataIn), 32'h0);
        check_val("rst_ioout", 32'(IoOut), 32'h0);
        check_val("rst_err", 32'(ErrAddr), 32'h0);
        @(negedge Clock);
        Reset = 1'b0;
        #1;

        // write then read-after-write
        access(1'b1, 16'd5, 16'hBEEF, 1'b0, 16'h0, 1'b0, "raw_wr");
        access(1'b0, 16'd5, 16'h0, 1'b0, 16'h0, 1'b0, "raw_rd");

        // back-to-back reads, ACKs RDL+1 cycles apart
        access(1'b1, 16'd1, 16'h0011, 1'b0, 16'h0, 1'b0, "pre1");
        access(1'b1, 16'd2, 16'h0022, 1'b0, 16'h0, 1'b0, "pre2");
        access(1'b0, 16'd1, 16'h0, 1'b0, 16'h0, 1'b0, "b2b1");
        t0 = last_ack;
        access(1'b0, 16'd2, 16'h0, 1'b0, 16'h0, 1'b0, "b2b2");
        check_val("b2b_gap", 32'(last_ack - t0), 32'((RDL + 1) * 10));

        // address changes while BUSY are ignored
        access(1'b1, 16'd9, 16'h0999, 1'b0, 16'h0, 1'b0, "pre9");
        access(1'b0, 16'd5, 16'h0, 1'b1, 16'd9, 1'b0, "midbusy");
        access(1'b0, 16'd9, 16'h0, 1'b0, 16'h0, 1'b0, "addr9");

        // I/O register
        access(1'b1, IOA, 16'h00A5, 1'b0, 16'h0, 1'b0, "io_wr");
        IoIn = 16'h1234;
        access(1'b0, IOA, 16'h0, 1'b0, 16'h0, 1'b0, "io_rd");

        // unmapped access; 16'h0800 aliases RAM word 0 if decode is wrong
        access(1'b1, 16'd0, 16'h0A0A, 1'b0, 16'h0, 1'b0, "pre0");
        access(1'b1, 16'h0800, 16'h5555, 1'b0, 16'h0, 1'b0, "unm_wr");
        access(1'b0, 16'd0, 16'h0, 1'b0, 16'h0, 1'b0, "unm_ram0");
        access(1'b0, 16'h0800, 16'h0, 1'b0, 16'h0, 1'b0, "unm_rd");

        // both strobes high counts as a write
        access(1'b1, 16'd7, 16'h0707, 1'b0, 16'h0, 1'b1, "both_wr");
        access(1'b0, 16'd7, 16'h0, 1'b0, 16'h0, 1'b0, "both_rd");

        // reset in the ACK cycle of a write must not commit it
        access(1'b1, 16'd3, 16'h0003, 1'b0, 16'h0, 1'b0, "pre3");
        DataAddr  = 16'd3;
        DataOut   = 16'h7777;
        WriteData = 1'b1;
        #1;
        check_val("rstw_req_wait", 32'(DataWaitreq), 32'h1);
        @(negedge Clock);
        Reset     = 1'b1;
        WriteData = 1'b0;
        #1;
        check_val("rstw_wait", 32'(DataWaitreq), 32'h0);
        check_val("rstw_data", 32'(DataIn), 32'h0);
        check_val("rstw_ioout", 32'(IoOut), 32'h0);
        check_val("rstw_err", 32'(ErrAddr), 32'h0);
        ref_io  = 16'h0;
        ref_err = 1'b0;
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        access(1'b0, 16'd3, 16'h0, 1'b0, 16'h0, 1'b0, "rstw_rd3");

        // reset while a read is BUSY
        DataAddr = 16'd5;
        ReadData = 1'b1;
        @(negedge Clock);
        Reset    = 1'b1;
        ReadData = 1'b0;
        #1;
        check_val("rstr_wait", 32'(DataWaitreq), 32'h0);
        check_val("rstr_data", 32'(DataIn), 32'h0);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        access(1'b0, 16'd5, 16'h0, 1'b0, 16'h0, 1'b0, "rstr_rd5");

        for (int i = 0; i < 60; i++) begin
            int          sel;
            logic [15:0] a;
            bit          wr;
            bit          both;
            sel = $urandom_range(0, 9);
            if (sel < 7)       a = 16'($urandom_range(0, 31));
            else if (sel == 7) a = IOA;
            else begin
                a = 16'($urandom_range(256, 65535));
                if (a == IOA) a = 16'h0FFF;
            end
            wr = 1'($urandom_range(0, 1));
            if (int'(a) < DEPTH && !ref_valid[a[7:0]]) wr = 1'b1;
            both = wr && ($urandom_range(0, 3) == 0);
            IoIn = 16'($urandom);
            access(wr, a, 16'($urandom), ($urandom_range(0, 2) == 0),
                   16'($urandom_range(0, 31)), both, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
